apb_rr_master: RTL and testbench

Shares one APB master port between `N_REQ` requesters using round-robin arbitration. It also sequences each granted request through the APB SETUP and ACCESS phases. It sits between the on-chip requesters and the APB slaves of the protocol block and replaces direct `transfer`/`READ_WRITE` driving. Responses carry read data and slave error back to the requester that issued the request.

---
 rtl/apb_arb_pkg.sv | 36 +++
 rtl/apb_rr_master_arbiter.sv | 32 +++
 rtl/apb_rr_master.sv | 173 +++++++++++++++++
 tb/tb_apb_rr_master.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the round-robin APB master.
//   apb_state_t : APB sequencing states (IDLE, SETUP, ACCESS)
//   DEF_*       : default parameter values for apb_rr_master
//   rr_next     : round-robin winner search over up to MAX_REQ requesters
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int DEF_N_REQ   = 2;
  localparam int DEF_ADDR_W  = 33;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  localparam int MAX_REQ = 8;
  localparam int PTR_W   = 3;

  // Returns the first set bit of vec strictly after ptr, wrapping. The search
  // runs modulo MAX_REQ; bits at or above the real requester count are held at
  // zero by the caller, so the result equals a modulo-N_REQ search. If vec is
  // empty the pointer is returned unchanged (caller qualifies with |vec).
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr,
                                               input logic [MAX_REQ-1:0] vec);
    logic [PTR_W-1:0] idx;
    rr_next = ptr;
    // Descending offsets, so the nearest candidate after ptr is written last.
    for (int unsigned k = MAX_REQ; k >= 1; k--) begin
      idx = ptr + PTR_W'(k);
      if (vec[idx]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/apb_rr_master_arbiter.sv
// Combinational round-robin arbiter.
//   req_i       : request vector
//   ptr_i       : index of the last granted requester
//   gnt_o       : one-hot grant
//   gnt_valid_o : at least one request present
//   gnt_idx_o   : binary index of the granted requester
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             gnt_valid_o,
  output logic [PTR_W-1:0] gnt_idx_o
);

  logic [MAX_REQ-1:0] vec;

  always_comb begin
    vec = '0;
    for (int unsigned i = 0; i < N_REQ; i++) vec[i] = req_i[i];
    gnt_valid_o = |req_i;
    gnt_idx_o   = rr_next(ptr_i, vec);
    gnt_o       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      gnt_o[i] = gnt_valid_o && (gnt_idx_o == PTR_W'(i));
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin shared APB master: arbitrates N_REQ requesters onto one APB
// port and sequences each granted request through SETUP and ACCESS.
// Optional feature macro: APB_ARB_TIMEOUT_EN (abort ACCESS after TIMEOUT
// cycles without PREADY, reporting rsp_err=1).
//   PCLK, PRESETn               : clock, async active-low reset
//   req_valid/write/addr/wdata  : per-requester request (packed vectors)
//   req_ack                     : combinational one-hot capture strobe
//   rsp_valid/rsp_rdata/rsp_err : registered completion to the owner
//   PSEL..PWDATA, PREADY..      : APB master port
module apb_rr_master
  import apb_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_write,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_ack,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [ADDR_W-1:0]        PADDR,
  output logic [DATA_W-1:0]        PWDATA,
  input  logic                     PREADY,
  input  logic [DATA_W-1:0]        PRDATA,
  input  logic                     PSLVERR
);

  apb_state_t         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [N_REQ-1:0]   gnt;
  logic               gnt_valid;
  logic [PTR_W-1:0]   gnt_idx;
  logic               xfer_done, timeout_hit, arb_en, grant;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

  // Counts ACCESS cycles of the current transfer; zero on ACCESS entry.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == ACCESS) to_cnt_d = to_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end

  assign timeout_hit = (state_q == ACCESS) && !PREADY &&
                       (to_cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign xfer_done = (state_q == ACCESS) && (PREADY || timeout_hit);
  assign arb_en    = (state_q == IDLE) || xfer_done;
  assign grant     = arb_en && gnt_valid;
  // Gated with PRESETn so no ack is shown while reset is held.
  assign req_ack   = gnt & {N_REQ{arb_en & PRESETn}};

  // Mux the granted requester's fields from the one-hot grant.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE:    if (grant) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (xfer_done) state_d = grant ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase

    if (xfer_done) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        rsp_valid_d[i] = (owner_q == PTR_W'(i));
      end
      rsp_rdata_d = (pwrite_q || !PREADY) ? '0 : PRDATA;
      rsp_err_d   = PREADY ? PSLVERR : 1'b1;
    end

    if (grant) begin
      ptr_d    = gnt_idx;
      owner_d  = gnt_idx;
      pwrite_d = sel_write;
      paddr_d  = sel_addr;
      pwdata_d = sel_wdata;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      ptr_q       <= PTR_W'(N_REQ - 1);
      owner_q     <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PSEL      = (state_q != IDLE);
  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master (3 requesters): directed scenarios
// followed by randomized traffic, compared every cycle with a
// transaction-level reference model.
module tb_apb_rr_master;
  localparam int N  = 3;
  localparam int AW = 33;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            PCLK = 1'b0;
  logic            PRESETn;
  logic [N-1:0]    req_valid, req_write, req_ack, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, PWDATA, PRDATA;
  logic            rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0]   PADDR;

  always #5 PCLK = ~PCLK;

  apb_rr_master #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ack(req_ack), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_have;      // a granted transfer is in flight
  int            m_age;       // cycles since its grant (1 = SETUP, >=2 = ACCESS)
  int            m_last;      // last granted requester
  int            m_idx;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [N-1:0]  m_rsp_vec;   // response expected in the current cycle
  logic [DW-1:0] m_rdata;     // held response data
  bit            m_err;
  int            grant_log[$];

  // stimulus state
  int            mode;        // 0 one-shot, 1 continuous, 2 random
  bit            acked[N];
  bit            s_fixed, s_stuck, s_err, f_err;
  int            s_wait, f_wait;
  logic [DW-1:0] s_rdata, f_rdata;

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_have = 0; m_age = 0; m_last = N - 1; m_idx = 0;
    m_rsp_vec = '0; m_rdata = '0; m_err = 0;
    for (int i = 0; i < N; i++) acked[i] = 0;
    s_wait = 0;
  endtask

  task automatic new_req(input int i);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    req_addr[i*AW +: AW]  = r[AW-1:0];
    req_wdata[i*DW +: DW] = $urandom();
    req_write[i]          = 1'($urandom_range(0, 1));
    req_valid[i]          = 1'b1;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_write[i]          = wr;
    req_valid[i]          = 1'b1;
  endtask

  // Sample at the falling edge and compare against the model, then advance it.
  task automatic sample();
    logic [N-1:0] exp_ack;
    bit           done;
    bit           to_abort;
    int           w;
    @(negedge PCLK);
    chk("psel", PSEL, m_have);
    chk("penable", PENABLE, m_have && m_age >= 2);
    if (m_have) begin
      chk("paddr", PADDR, m_addr);
      chk("pwrite", PWRITE, m_wr);
      chk("pwdata", PWDATA, m_wdata);
    end
    chk("rsp_valid", rsp_valid, m_rsp_vec);
    chk("rsp_rdata", rsp_rdata, m_rdata);
    if (m_rsp_vec != 0) chk("rsp_err", rsp_err, m_err);

    to_abort = 0;
`ifdef APB_ARB_TIMEOUT_EN
    to_abort = m_have && !PREADY && (m_age - 1 == TO);
`endif
    done = m_have && m_age >= 2 && (PREADY || to_abort);
    w = (!m_have || done) ? rr_pick(m_last, req_valid) : -1;
    exp_ack = '0;
    if (w >= 0) exp_ack[w] = 1'b1;
    chk("req_ack", req_ack, exp_ack);

    m_rsp_vec = '0;
    if (done) begin
      m_rsp_vec[m_idx] = 1'b1;
      m_rdata = (m_wr || !PREADY) ? '0 : PRDATA;
      m_err   = PREADY ? PSLVERR : 1'b1;
      m_have  = 0;
    end
    if (w >= 0) begin
      m_have = 1; m_age = 0; m_idx = w; m_last = w;
      m_wr    = req_write[w];
      m_addr  = req_addr[w*AW +: AW];
      m_wdata = req_wdata[w*DW +: DW];
      grant_log.push_back(w);
      acked[w] = 1;
    end
    if (m_have) m_age++;

    // slave BFM bookkeeping
    if (PSEL && !PENABLE) begin
      if (s_fixed) begin
        s_wait = f_wait; s_rdata = f_rdata; s_err = f_err;
      end else begin
        s_wait = $urandom_range(0, 3); s_rdata = $urandom();
        s_err = ($urandom_range(0, 7) == 0);
      end
    end else if (PSEL && PENABLE && !PREADY && s_wait > 0) begin
      s_wait--;
    end
  endtask

  // Move past the rising edge and update requester and slave drive.
  task automatic advance();
    @(posedge PCLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (mode == 0) begin
        if (acked[i]) begin acked[i] = 0; req_valid[i] = 1'b0; end
      end else if (mode == 1) begin
        if (acked[i]) begin acked[i] = 0; new_req(i); end
      end else begin
        if (acked[i]) begin
          acked[i] = 0;
          if ($urandom_range(0, 1) == 1) new_req(i); else req_valid[i] = 1'b0;
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) new_req(i);
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    PREADY  = PSEL && PENABLE && !s_stuck && (s_wait == 0);
    PRDATA  = s_rdata;
    PSLVERR = PREADY && s_err;
  endtask

  task automatic run_until_rsp(input int bound, output int acc);
    acc = 0;
    for (int k = 0; k < bound; k++) begin
      sample();
      if (PSEL && PENABLE) acc++;
      if (rsp_valid != 0) break;
      advance();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, span, idle;
    bit started;
    PRESETn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    mode = 0; s_fixed = 1; s_stuck = 0; s_err = 0; s_rdata = '0;
    f_wait = 0; f_rdata = '0; f_err = 0;
    model_reset();

    // reset state
    sample();
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_rsp_err", rsp_err, 0);
    advance();
    sample();
    advance();
    PRESETn = 1'b1;

    // single write, zero-wait slave
    f_wait = 0; f_err = 0;
    set_req(0, 1, 33'd526, 32'd9);
    sample(); chk("w_ack", req_ack, 3'b001); advance();
    sample();
    chk("w_setup", {PSEL, PENABLE}, 2'b10);
    chk("w_paddr", PADDR, 526); chk("w_pwrite", PWRITE, 1); chk("w_pwdata", PWDATA, 9);
    advance();
    sample(); chk("w_access", {PSEL, PENABLE}, 2'b11); advance();
    sample(); chk("w_rsp", rsp_valid, 3'b001); chk("w_err", rsp_err, 0); advance();

    // read with three wait states
    f_wait = 3; f_rdata = 32'h35;
    set_req(1, 0, 33'd45, 32'd0);
    run_until_rsp(20, acc);
    chk("rd_access_cycles", acc, 4);
    chk("rd_rsp", rsp_valid, 3'b010);
    chk("rd_data", rsp_rdata, 32'h35);
    advance();

    // slave error, then a normal request
    f_wait = 0; f_err = 1;
    set_req(0, 1, 33'd22, 32'h1234);
    run_until_rsp(20, acc);
    chk("err_rsp", rsp_valid, 3'b001);
    chk("err_flag", rsp_err, 1);
    advance();
    f_err = 0;
    set_req(0, 0, 33'd23, 32'd0);
    f_rdata = 32'hCAFE;
    run_until_rsp(20, acc);
    chk("after_err_rsp", rsp_valid, 3'b001);
    chk("after_err_flag", rsp_err, 0);
    chk("after_err_data", rsp_rdata, 32'hCAFE);
    advance();

    // contention between requesters 0 and 1
    mode = 1; grant_log.delete();
    new_req(0); new_req(1);
    started = 0; span = 0; idle = 0;
    for (int k = 0; k < 60; k++) begin
      sample();
      if (started) begin span++; if (!PSEL) idle++; end
      if (grant_log.size() >= 8) break;
      if (grant_log.size() >= 1) started = 1;
      advance();
    end
    advance();
    mode = 0; req_valid = '0;
    for (int i = 0; i < N; i++) acked[i] = 0;
    chk("ctn_count", grant_log.size(), 8);
    for (int k = 0; k < grant_log.size() && k < 8; k++)
      chk($sformatf("ctn_order%0d", k), grant_log[k], (k % 2 == 0) ? 1 : 0);
    chk("ctn_span", span, 14);
    chk("ctn_idle", idle, 0);
    repeat (6) begin sample(); advance(); end

    // reset during ACCESS
    f_wait = 5;
    set_req(2, 0, 33'h1_0000_0100, 32'd0);
    for (int k = 0; k < 10; k++) begin
      sample();
      if (PENABLE) break;
      advance();
    end
    chk("rst_mid_in_access", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_mid_psel", PSEL, 0);
    chk("rst_mid_penable", PENABLE, 0);
    chk("rst_mid_paddr", PADDR, 0);
    chk("rst_mid_rsp", rsp_valid, 0);
    model_reset();
    req_valid = '0;
    f_wait = 0;
    advance(); sample(); advance(); sample(); advance();
    PRESETn = 1'b1;
    set_req(0, 1, 33'd100, 32'd1);
    set_req(1, 1, 33'd200, 32'd2);
    sample(); chk("rst_first_ack", req_ack, 3'b001); advance();
    repeat (8) begin sample(); advance(); end

`ifdef APB_ARB_TIMEOUT_EN
    // slave never ready
    s_stuck = 1;
    set_req(1, 0, 33'd77, 32'd0);
    run_until_rsp(40, acc);
    chk("to_access_cycles", acc, TO);
    chk("to_rsp", rsp_valid, 3'b010);
    chk("to_err", rsp_err, 1);
    chk("to_data", rsp_rdata, 0);
    advance();
    s_stuck = 0;
    repeat (3) begin sample(); advance(); end
`endif

    // randomized traffic
    mode = 2; s_fixed = 0;
    repeat (3000) begin sample(); advance(); end
    mode = 0; req_valid = '0;
    for (int i = 0; i < N; i++) acked[i] = 0;
    repeat (20) begin sample(); advance(); end
    chk("final_idle", PSEL, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
